// File: rtl/cpuc_mem_loader_if.sv
// Byte-stream handshake between a download source and the memory loader.
// The master drives bytes; the slave (loader) answers with in_ready.
interface cpuc_mem_loader_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/cpuc_mem_loader.sv
// Front-end mux for the CPUC RAM: passes CPU accesses through when idle, or stalls
// the CPU and writes a little-endian byte stream into consecutive RAM words.
module cpuc_mem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [LEN_WIDTH-1:0]  load_len,
    cpuc_mem_loader_if.slave      stream,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic                  cpu_wren,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  load_busy,
    output logic                  load_done
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                state, state_next;
    logic [BCW-1:0]        byte_cnt;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  accept;

    assign accept = stream.in_valid && stream.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: capture on start, pack bytes into lanes, count written words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            shreg    <= '0;
            base_q   <= '0;
            len_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= load_base;
                        len_q    <= load_len;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        shreg[{byte_cnt, 3'b000} +: 8] <= stream.in_byte;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state and the RAM-side mux; WRITE is the only state where the loader owns the RAM.
    always_comb begin
        state_next      = state;
        stream.in_ready = 1'b0;
        cpu_hold        = 1'b1;
        load_busy       = 1'b1;
        load_done       = 1'b0;
        ram_address     = cpu_address;
        ram_wren        = 1'b0;
        ram_data        = cpu_data;

        case (state)
            IDLE: begin
                cpu_hold  = 1'b0;
                load_busy = 1'b0;
                ram_wren  = cpu_wren;
                if (start) begin
                    state_next = (load_len == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                stream.in_ready = 1'b1;
                if (accept && (byte_cnt == LAST_BYTE)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                ram_wren    = 1'b1;
                ram_address = base_q + ADDR_WIDTH'(word_cnt);
                ram_data    = shreg;
                state_next  = ((word_cnt + 1'b1) == len_q) ? DONE : COLLECT;
            end
            DONE: begin
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpuc_mem_loader.sv
// Randomized scoreboard bench for cpuc_mem_loader: a word-level model fills the
// expected-write queue, a negedge monitor pops and compares every loader write.
module tb_cpuc_mem_loader;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] load_base = '0;
    logic [15:0] load_len = '0;
    logic [31:0] cpu_address = '0;
    logic        cpu_wren = 1'b0;
    logic [31:0] cpu_data = '0;
    logic        cpu_hold;
    logic [31:0] ram_address;
    logic        ram_wren;
    logic [31:0] ram_data;
    logic        load_busy;
    logic        load_done;

    cpuc_mem_loader_if intf ();

    cpuc_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .load_base(load_base), .load_len(load_len),
        .stream(intf.slave),
        .cpu_address(cpu_address), .cpu_wren(cpu_wren), .cpu_data(cpu_data),
        .cpu_hold(cpu_hold), .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_data(ram_data), .load_busy(load_busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails = 0;
    int          cyc = 0;
    int          exp_done = 0;
    int          last_write_cyc = -1;
    int          last_done_cyc = -1;
    int          start_cyc = 0;
    bit          saw_ready = 1'b0;
    wr_t         exp_q[$];
    logic [7:0]  pend_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic report(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        report(act === exp, name, act, exp);
    endtask

    // Monitor: loader-owned writes are those with cpu_hold asserted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wren && cpu_hold) begin
                last_write_cyc = cyc;
                if (exp_q.size() == 0) begin
                    report(1'b0, "unexpected_write", {32'h0, ram_address}, 64'h0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_val("write_addr", ram_address, e.addr);
                    check_val("write_data", ram_data, e.data);
                end
            end
            if (load_done) begin
                last_done_cyc = cyc;
                if (exp_done == 0) begin
                    report(1'b0, "unexpected_done", 64'h1, 64'h0);
                end else begin
                    exp_done--;
                end
            end
            if (intf.in_ready) saw_ready = 1'b1;
        end
    end

    task automatic randomize_cpu();
        cpu_address = $urandom;
        cpu_wren    = 1'($urandom_range(1));
        cpu_data    = $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        intf.in_valid = 1'b1;
        intf.in_byte  = b;
        while (!intf.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) report(1'b0, "byte_accept_timeout", 64'h0, 64'h1);
        if ($urandom_range(3) == 0) begin
            start     = 1'b1;
            load_base = $urandom;
            load_len  = 16'($urandom);
        end
        randomize_cpu();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (load_busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) report(1'b0, "idle_timeout", 64'h1, 64'h0);
    endtask

    // Reference model: word i is bytes 4i..4i+3 little-endian, at (base+i) mod 2^32.
    task automatic model_push(input logic [31:0] base, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            wr_t w;
            w.addr = base + 32'(i);
            w.data = {pend_bytes[4*i+3], pend_bytes[4*i+2], pend_bytes[4*i+1], pend_bytes[4*i]};
            exp_q.push_back(w);
        end
    endtask

    task automatic issue_start(input logic [31:0] base, input logic [15:0] len);
        start     = 1'b1;
        load_base = base;
        load_len  = len;
        randomize_cpu();
        @(negedge clk);
        start_cyc = cyc;
        start     = 1'b0;
        cpu_wren  = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] base, input int len, input bit gaps);
        if (pend_bytes.size() != 4 * len) begin
            pend_bytes.delete();
            for (int i = 0; i < 4 * len; i++) pend_bytes.push_back(8'($urandom));
        end
        model_push(base, len);
        exp_done++;
        issue_start(base, 16'(len));
        for (int i = 0; i < 4 * len; i++) begin
            if (gaps && $urandom_range(2) == 0) begin
                intf.in_valid = 1'b0;
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
            send_byte(pend_bytes[i]);
        end
        intf.in_valid = 1'b0;
        wait_idle();
        pend_bytes.delete();
    endtask

    task automatic check_output(input string tag);
        check_val({tag, "_pending_writes"}, 64'(exp_q.size()), 64'h0);
        check_val({tag, "_pending_done"}, 64'(exp_done), 64'h0);
        check_val({tag, "_cpu_hold_idle"}, {63'h0, cpu_hold}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        intf.in_valid = 1'b0;
        intf.in_byte  = '0;
        #1;
        check_val("reset_in_ready", {63'h0, intf.in_ready}, 64'h0);
        check_val("reset_cpu_hold", {63'h0, cpu_hold}, 64'h0);
        check_val("reset_busy", {63'h0, load_busy}, 64'h0);
        check_val("reset_done", {63'h0, load_done}, 64'h0);
        check_val("reset_ram_wren", {63'h0, ram_wren}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through in IDLE
        cpu_address = 32'd5;
        cpu_wren    = 1'b1;
        cpu_data    = 32'hDEADBEEF;
        #1;
        check_val("pass_addr", ram_address, 32'd5);
        check_val("pass_wren", {63'h0, ram_wren}, 64'h1);
        check_val("pass_data", ram_data, 32'hDEADBEEF);
        check_val("pass_hold", {63'h0, cpu_hold}, 64'h0);
        check_val("pass_ready", {63'h0, intf.in_ready}, 64'h0);
        cpu_wren = 1'b0;
        @(negedge clk);

        // Single word with continuous valid and exact latency
        pend_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
        apply_stimulus(32'h10, 1, 1'b0);
        check_val("single_write_latency", 64'(last_write_cyc - start_cyc), 64'd4);
        check_val("single_done_latency", 64'(last_done_cyc - last_write_cyc), 64'd1);
        check_output("single");

        // Multi-word with back-pressure gaps
        apply_stimulus(32'h20, 3, 1'b1);
        check_output("multi");

        // Zero length
        saw_ready = 1'b0;
        exp_done++;
        issue_start(32'h40, 16'd0);
        wait_idle();
        check_val("zero_done_latency", 64'(last_done_cyc - start_cyc), 64'd0);
        check_val("zero_no_ready", {63'h0, saw_ready}, 64'h0);
        check_output("zero");

        // Address wrap
        apply_stimulus(32'hFFFFFFFF, 2, 1'b1);
        check_output("wrap");

        // Random loads
        for (int k = 0; k < 6; k++) begin
            apply_stimulus($urandom, int'($urandom_range(5, 1)), 1'b1);
            check_output("random");
        end

        // Reset mid-load after two bytes of the second word
        pend_bytes.delete();
        for (int i = 0; i < 8; i++) pend_bytes.push_back(8'($urandom));
        model_push(32'h80, 1);
        issue_start(32'h80, 16'd2);
        for (int i = 0; i < 6; i++) send_byte(pend_bytes[i]);
        cpu_wren = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst_cpu_hold", {63'h0, cpu_hold}, 64'h0);
        check_val("rst_in_ready", {63'h0, intf.in_ready}, 64'h0);
        check_val("rst_ram_wren", {63'h0, ram_wren}, 64'h0);
        check_val("rst_first_word_written", 64'(exp_q.size()), 64'h0);
        intf.in_valid = 1'b0;
        pend_bytes.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_release_busy", {63'h0, load_busy}, 64'h0);
        apply_stimulus(32'h90, 1, 1'b0);
        check_output("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
